// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared constants and helpers for the iterative multiply/divide unit
package muldiv_unit_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  function automatic logic md_signed_a(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
  endfunction

  function automatic logic md_signed_b(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response handshake bundle between the EX stage and muldiv_unit
interface muldiv_unit_if
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = MD_XLEN
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, funct3, rdata1, rdata2, kill, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, rdata1, rdata2, kill, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - conditional two's-complement negation of a WIDTH-bit value
module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  // Negating 100..0 wraps back to itself, which is the correct unsigned magnitude.
  assign out = neg ? (~in + {{(WIDTH-1){1'b0}}, 1'b1}) : in;
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one bit per cycle on operand magnitudes
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN     = MD_XLEN,
  parameter int CNT_BITS = $clog2(XLEN) + 1
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);
  logic [1:0]          state;
  logic [CNT_BITS-1:0] cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opb;
  logic [2:0]          op;
  logic                neg_res;
  logic                neg_rem;
  logic [XLEN-1:0]     result_q;

  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  assign sign_a = md_signed_a(bus.funct3) & bus.rdata1[XLEN-1];
  assign sign_b = md_signed_b(bus.funct3) & bus.rdata2[XLEN-1];

  muldiv_negate #(.WIDTH(XLEN)) u_abs_a (.neg(sign_a), .in(bus.rdata1), .out(mag_a));
  muldiv_negate #(.WIDTH(XLEN)) u_abs_b (.neg(sign_b), .in(bus.rdata2), .out(mag_b));

  assign div_zero = bus.funct3[2] && (bus.rdata2 == '0);
  assign div_ovf  = ((bus.funct3 == MD_DIV) || (bus.funct3 == MD_REM))
                 && (bus.rdata1 == {1'b1, {(XLEN-1){1'b0}}})
                 && (bus.rdata2 == '1);

  // Quotient of x/0 is all-ones, remainder is x; overflow gives quotient x, remainder 0.
  always_comb begin
    special_res = bus.rdata1;
    if (div_zero && !bus.funct3[1])
      special_res = '1;
    else if (div_ovf && bus.funct3[1])
      special_res = '0;
  end

  // Multiply keeps {product_hi, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] acc_step;
  logic              unused_bits;

  assign mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
  assign div_shift   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff    = {1'b0, div_shift} - {2'b00, opb};
  assign unused_bits = ^{div_shift[XLEN], div_diff[XLEN]};

  always_comb begin
    acc_step = {1'b0, acc[2*XLEN-1:1]};
    if (op[2]) begin
      if (div_diff[XLEN+1])
        acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else if (acc[0]) begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   final_res;

  muldiv_negate #(.WIDTH(2*XLEN)) u_fix_prod (.neg(neg_res), .in(acc_step), .out(prod));
  muldiv_negate #(.WIDTH(XLEN)) u_fix_quo (.neg(neg_res), .in(acc_step[XLEN-1:0]), .out(quo));
  muldiv_negate #(.WIDTH(XLEN)) u_fix_rem (.neg(neg_rem), .in(acc_step[2*XLEN-1:XLEN]), .out(rem));

  always_comb begin
    final_res = rem;
    case (op)
      MD_MUL:                       final_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              final_res = quo;
      default:                      final_res = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      op       <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (bus.in_valid && !bus.kill) begin
            op      <= bus.funct3;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            if (div_zero || div_ovf) begin
              result_q <= special_res;
              state    <= MD_DONE;
            end else begin
              cnt   <= CNT_BITS'(XLEN);
              acc   <= {{XLEN{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
              opb   <= bus.funct3[2] ? mag_b : mag_a;
              state <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          if (bus.kill) begin
            state <= MD_IDLE;
          end else begin
            acc <= acc_step;
            cnt <= cnt - CNT_BITS'(1);
            if (cnt == CNT_BITS'(1)) begin
              result_q <= final_res;
              state    <= MD_DONE;
            end
          end
        end
        MD_DONE: begin
          if (bus.kill || bus.out_ready)
            state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == MD_IDLE);
  assign bus.out_valid = (state == MD_DONE);
  assign bus.result    = result_q;

endmodule
